// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic pipeline stage register with valid/ready handshake,
// stall back-pressure, synchronous flush, control squashing and a saturating
// stall counter.
// Optional feature macro: PIPE_STAGE_SKID_EN
//   defined   -> 2-entry (main + skid) buffer, in_ready is a registered signal
//   undefined -> 1-entry buffer, in_ready = !valid_q || out_ready
module pipe_stage_reg #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic              accept;
    logic              out_xfer;

    assign accept   = in_valid && in_ready;
    assign out_xfer = valid_q && out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    // Ready depends only on state, so out_ready never reaches in_ready combinationally.
    assign in_ready = !skid_valid;

    // Main + skid buffer; skid drains into main first so ordering is preserved.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            data_q     <= '0;
            ctrl_q     <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_ctrl  <= '0;
        end else if (flush) begin
            // Payload registers keep their old contents; only validity is squashed.
            valid_q    <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_xfer && skid_valid) begin
            // in_ready is low while skid is full, so no accept can coincide here.
            data_q     <= skid_data;
            ctrl_q     <= skid_ctrl;
            skid_valid <= 1'b0;
        end else if (accept) begin
            if (!valid_q || out_ready) begin
                valid_q <= 1'b1;
                data_q  <= in_data;
                ctrl_q  <= in_ctrl;
            end else begin
                skid_valid <= 1'b1;
                skid_data  <= in_data;
                skid_ctrl  <= in_ctrl;
            end
        end else if (out_xfer) begin
            valid_q <= 1'b0;
        end
    end
`else
    // Single entry: can take a new item when empty or when the held one leaves this cycle.
    assign in_ready = !valid_q || out_ready;

    // Single-entry holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else if (flush) begin
            // Anything accepted this cycle is discarded along with the held entry.
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            data_q  <= in_data;
            ctrl_q  <= in_ctrl;
        end else if (out_xfer) begin
            valid_q <= 1'b0;
        end
    end
`endif

    // Count back-pressured cycles, sticking at all-ones; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (valid_q && !out_ready && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    // Control bits must never assert downstream actions for a bubble.
    assign out_ctrl  = valid_q ? ctrl_q : '0;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed bench with a queue-based reference model of the
// stage, compared against the DUT every cycle, plus literal spot checks.
module tb_pipe_stage_reg;

    localparam int DW    = 96;
    localparam int CW    = 3;
    localparam int CNT_W = 10;
    localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [CNT_W-1:0] stall_cnt;

    int errs   = 0;
    int checks = 0;

    // Reference model: ordered list of held entries plus last main payload.
    logic [DW-1:0] qd[$];
    logic [CW-1:0] qc[$];
    logic [DW-1:0] mdata;
    int            mcnt;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ctrl(out_ctrl), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_rdy(input logic ordy);
        if (CAP == 2) return qd.size() < 2;
        return (qd.size() == 0) || ordy;
    endfunction

    task automatic model_reset();
        qd.delete();
        qc.delete();
        mdata = '0;
        mcnt  = 0;
    endtask

    task automatic compare();
        chk("out_valid", 128'(out_valid), 128'(qd.size() > 0));
        chk("out_data", 128'(out_data), 128'(mdata));
        chk("out_ctrl", 128'(out_ctrl), (qd.size() > 0) ? 128'(qc[0]) : 128'd0);
        chk("stall_cnt", 128'(stall_cnt), 128'(mcnt));
        chk("in_ready", 128'(in_ready), 128'(model_rdy(out_ready)));
    endtask

    // Drive one cycle of inputs, check DUT vs model mid-cycle, then advance model at the edge.
    task automatic cyc(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic ordy, input logic fl);
        logic rdy, pop, acc;
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        compare();
        rdy = model_rdy(ordy);
        pop = (qd.size() > 0) && ordy;
        acc = iv && rdy;
        if ((qd.size() > 0) && !ordy && (mcnt != CMAX)) mcnt++;
        @(posedge clk);
        if (pop) begin
            void'(qd.pop_front());
            void'(qc.pop_front());
        end
        if (acc) begin
            qd.push_back(d);
            qc.push_back(c);
        end
        if (fl) begin
            qd.delete();
            qc.delete();
        end else if (qd.size() > 0) begin
            mdata = qd[0];
        end
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
        model_reset();
        #12;
        chk("rst out_valid", 128'(out_valid), 128'd0);
        chk("rst out_data", 128'(out_data), 128'd0);
        chk("rst out_ctrl", 128'(out_ctrl), 128'd0);
        chk("rst stall_cnt", 128'(stall_cnt), 128'd0);
        chk("rst in_ready", 128'(in_ready), 128'd1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Streaming at full throughput
        cyc(1, 96'd1, 3'b001, 1, 0);
        chk("stream d1", 128'(out_data), 128'd1);
        chk("stream v1", 128'(out_valid), 128'd1);
        cyc(1, 96'd2, 3'b010, 1, 0);
        chk("stream d2", 128'(out_data), 128'd2);
        chk("stream v2", 128'(out_valid), 128'd1);
        cyc(1, 96'd3, 3'b011, 1, 0);
        chk("stream d3", 128'(out_data), 128'd3);
        cyc(0, 96'd0, 3'b000, 1, 0);
        chk("stream drained", 128'(out_valid), 128'd0);
        chk("stream data kept", 128'(out_data), 128'd3);

        // Stall with one entry held
        cyc(1, 96'd5, 3'b110, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 96'd0, 3'b000, 0, 0);
        chk("stall data held", 128'(out_data), 128'd5);
        chk("stall cnt 4", 128'(stall_cnt), 128'd4);
        chk("stall ctrl held", 128'(out_ctrl), 128'd6);
        cyc(1, 96'd6, 3'b001, 0, 0);
        cyc(1, 96'd6, 3'b001, 1, 0);
        cyc(0, 96'd0, 3'b000, 1, 0);
        cyc(0, 96'd0, 3'b000, 1, 0);
        chk("stall both out", 128'(out_valid), 128'd0);
        chk("stall last data", 128'(out_data), 128'd6);

        // Push A, B under back-pressure, then release
        cyc(1, 96'hA, 3'b001, 0, 0);
        cyc(1, 96'hB, 3'b010, 0, 0);
`ifdef PIPE_STAGE_SKID_EN
        chk("skid in_ready low", 128'(in_ready), 128'd0);
`endif
        cyc(1, 96'hB, 3'b010, 1, 0);
        cyc(0, 96'd0, 3'b000, 1, 0);
`ifdef PIPE_STAGE_SKID_EN
        chk("skid B after A", 128'(out_data), 128'hB);
        chk("skid in_ready back", 128'(in_ready), 128'd1);
`endif
        cyc(0, 96'd0, 3'b000, 1, 0);
        cyc(0, 96'd0, 3'b000, 1, 0);

        // Flush squashes held entry and the one accepted in the same cycle
        cyc(1, 96'h77, 3'b101, 0, 0);
        chk("pre-flush ctrl", 128'(out_ctrl), 128'h5);
        cyc(1, 96'h88, 3'b011, 1, 1);
        chk("flush valid", 128'(out_valid), 128'd0);
        chk("flush ctrl", 128'(out_ctrl), 128'd0);
        chk("flush data kept", 128'(out_data), 128'h77);
        cyc(0, 96'd0, 3'b000, 1, 0);
        chk("flush input dropped", 128'(out_valid), 128'd0);

        // Mixed directed traffic pattern
        for (int i = 0; i < 120; i++)
            cyc((i % 3) != 0, DW'(i * 32'h1111), CW'(i), (i % 4) != 1, (i == 37) || (i == 90));
        cyc(0, 96'd0, 3'b000, 1, 0);
        cyc(0, 96'd0, 3'b000, 1, 0);

        // Saturation: hold an entry back-pressured past 2**CNT_W cycles
        cyc(1, 96'h3C, 3'b111, 0, 0);
        for (int i = 0; i < (1 << CNT_W) + 4; i++) cyc(0, 96'd0, 3'b000, 0, 0);
        chk("stall_cnt saturated", 128'(stall_cnt), 128'h3FF);
        chk("sat data held", 128'(out_data), 128'h3C);

        // Asynchronous reset in the middle of traffic
        cyc(1, 96'h11, 3'b001, 0, 0);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid rst out_valid", 128'(out_valid), 128'd0);
        chk("mid rst out_data", 128'(out_data), 128'd0);
        chk("mid rst out_ctrl", 128'(out_ctrl), 128'd0);
        chk("mid rst stall_cnt", 128'(stall_cnt), 128'd0);
        chk("mid rst in_ready", 128'(in_ready), 128'd1);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        chk("post rst in_ready", 128'(in_ready), 128'd1);
        cyc(1, 96'h42, 3'b100, 1, 0);
        chk("post rst accept", 128'(out_data), 128'h42);
        cyc(0, 96'd0, 3'b000, 1, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
